// File: rtl/pe_arr_pkg.sv
// Shared widths, saturation helper and datapath types for the PE array accumulator.
package pe_arr_pkg;

  // Default lane configuration; the typedefs below are sized for it.
  localparam int IFM_WIDTH_DEF   = 8;
  localparam int WGT_WIDTH_DEF   = 8;
  localparam int PE_ARR_SIZE_DEF = 9;

  // Full-precision width of one signed lane product.
  function automatic int prod_w(input int ifm_w, input int wgt_w);
    return ifm_w + wgt_w;
  endfunction

  // Lossless width of the sum of n products of width p_w.
  function automatic int sum_w(input int p_w, input int n);
    return p_w + $clog2(n);
  endfunction

  // Wide signed carrier used for saturation arithmetic; every datapath
  // width in this block stays well below 64 bits.
  typedef logic signed [63:0] wide_t;

  // Clamp v to the signed range of a width-bit two's-complement number.
  function automatic wide_t sat_to(input wide_t v, input int width);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (width - 1)) - wide_t'(1);
    lo = -hi - wide_t'(1);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  localparam int PROD_W_DEF = prod_w(IFM_WIDTH_DEF, WGT_WIDTH_DEF);
  localparam int SUM_W_DEF  = sum_w(PROD_W_DEF, PE_ARR_SIZE_DEF);

  typedef logic signed [PROD_W_DEF-1:0] prod_t;
  typedef prod_t                        prod_vec_t [PE_ARR_SIZE_DEF];
  typedef logic signed [SUM_W_DEF-1:0]  sum_t;

endpackage

// File: rtl/pe_arr_acc_sum_tree.sv
// Combinational signed adder tree: reduces N products to one lossless sum.
// Odd node counts at any level pass the unpaired node straight up.
module pe_sum_tree
  import pe_arr_pkg::*;
#(
  parameter int PROD_W = 16,
  parameter int N      = 9,
  parameter int SUM_W  = sum_w(PROD_W, N)
) (
  input  logic signed [PROD_W-1:0] prod [N],
  output logic signed [SUM_W-1:0]  sum
);

  localparam int LEVELS = $clog2(N);

  // Number of nodes present at a given tree level (level 0 = leaves).
  function automatic int nodes_at(input int lvl);
    int c;
    c = N;
    for (int k = 0; k < lvl; k++) c = (c + 1) / 2;
    return c;
  endfunction

  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int CNT = nodes_at(l);
    logic signed [SUM_W-1:0] node [CNT];

    if (l == 0) begin : g_leaf
      // Sign-extend each product to the full sum width up front so every
      // adder below is the same width and cannot overflow.
      for (genvar i = 0; i < CNT; i++) begin : g_ext
        assign node[i] = SUM_W'(prod[i]);
      end
    end else begin : g_add
      localparam int PREV = nodes_at(l - 1);
      for (genvar i = 0; i < CNT; i++) begin : g_pair
        if (2 * i + 1 < PREV) begin : g_sum
          assign node[i] = g_lvl[l-1].node[2*i] + g_lvl[l-1].node[2*i+1];
        end else begin : g_pass
          assign node[i] = g_lvl[l-1].node[2*i];
        end
      end
    end
  end

  assign sum = g_lvl[LEVELS].node[0];

endmodule

// File: rtl/pe_arr_acc.sv
// PE array accumulator: N signed multipliers, adder tree, multi-beat channel
// accumulator with bias, optional ReLU and output saturation. Three pipeline
// stages under valid/ready flow control; the whole pipe stalls on backpressure.
module pe_arr_acc
  import pe_arr_pkg::*;
#(
  parameter int IFM_WIDTH    = 8,
  parameter int WGT_WIDTH    = 8,
  parameter int BIAS_WIDTH   = 8,
  parameter int PE_ARR_SIZE  = 9,
  parameter int ACC_WIDTH    = 32,
  parameter int OUTPUT_WIDTH = 20
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_last,
  input  logic                           relu_en,
  input  logic signed [BIAS_WIDTH-1:0]   bias_input,
  input  logic signed [IFM_WIDTH-1:0]    ifm_input [PE_ARR_SIZE],
  input  logic signed [WGT_WIDTH-1:0]    wgt_input [PE_ARR_SIZE],
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [OUTPUT_WIDTH-1:0] ofm_output,
  output logic                           out_sat
);

  localparam int PROD_W = prod_w(IFM_WIDTH, WGT_WIDTH);
  localparam int SUM_W  = sum_w(PROD_W, PE_ARR_SIZE);

  // Flow control: every stage moves together whenever the output slot is
  // free or being drained this cycle.
  logic adv;
  logic accept;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && !rst;
  assign accept   = in_valid && in_ready;

  logic first_beat;

  logic                         s1_valid, s1_last, s1_first, s1_relu;
  logic signed [BIAS_WIDTH-1:0] s1_bias;
  logic signed [PROD_W-1:0]     s1_prod [PE_ARR_SIZE];

  logic                         s2_valid, s2_last, s2_first, s2_relu;
  logic signed [BIAS_WIDTH-1:0] s2_bias;
  logic signed [SUM_W-1:0]      s2_sum;
  logic signed [SUM_W-1:0]      tree_sum;

  logic signed [ACC_WIDTH-1:0]  acc;
  logic                         acc_ovf;
  logic signed [BIAS_WIDTH-1:0] grp_bias;
  logic                         grp_relu;

  wide_t                        acc_raw, acc_sat, fin_raw, fin_sat;
  logic signed [ACC_WIDTH-1:0]  acc_next;
  logic                         ovf_next;
  logic signed [BIAS_WIDTH-1:0] fin_bias;
  logic                         fin_relu;
  logic                         fin_clip;

  // Track whether the next accepted beat opens a new group.
  // NOTE: sequential state is written with non-blocking (<=) assignments so
  // every flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      first_beat <= 1'b1;
    end else if (accept) begin
      first_beat <= in_last;
    end
  end

  // Stage S1: register lane products and the beat's sideband.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (adv) begin
      s1_valid <= accept;
    end
    // NOTE: only the valid bits are reset; data registers are qualified by
    // their valid and skipping their reset keeps the reset net off the datapath.
    if (adv) begin
      s1_last  <= in_last;
      s1_first <= first_beat;
      s1_relu  <= relu_en;
      s1_bias  <= bias_input;
      for (int i = 0; i < PE_ARR_SIZE; i++) begin
        s1_prod[i] <= PROD_W'(ifm_input[i]) * PROD_W'(wgt_input[i]);
      end
    end
  end

  pe_sum_tree #(
    .PROD_W (PROD_W),
    .N      (PE_ARR_SIZE),
    .SUM_W  (SUM_W)
  ) u_sum_tree (
    .prod (s1_prod),
    .sum  (tree_sum)
  );

  // Stage S2: register the tree sum and carry the sideband along.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
    end else if (adv) begin
      s2_valid <= s1_valid;
    end
    if (adv) begin
      s2_last  <= s1_last;
      s2_first <= s1_first;
      s2_relu  <= s1_relu;
      s2_bias  <= s1_bias;
      s2_sum   <= tree_sum;
    end
  end

  // Next accumulator value and the finalised result for a closing beat.
  // NOTE: every variable gets a value on every path through this block
  // (computed unconditionally or defaulted first), so no latch is inferred.
  always_comb begin
    fin_bias = s2_first ? s2_bias : grp_bias;
    fin_relu = s2_first ? s2_relu : grp_relu;

    acc_raw  = s2_first ? wide_t'(s2_sum) : wide_t'(acc) + wide_t'(s2_sum);
    acc_sat  = sat_to(acc_raw, ACC_WIDTH);
    acc_next = ACC_WIDTH'(acc_sat);
    ovf_next = (acc_sat != acc_raw) || (!s2_first && acc_ovf);

    fin_raw  = wide_t'(acc_next) + wide_t'(fin_bias);
    if (fin_relu && fin_raw < 0) fin_raw = '0;
    fin_sat  = sat_to(fin_raw, OUTPUT_WIDTH);
    fin_clip = (fin_sat != fin_raw);
  end

  // Stage S3: accumulate, capture group bias/ReLU, and load the output slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      acc_ovf    <= 1'b0;
      out_valid  <= 1'b0;
      ofm_output <= '0;
      out_sat    <= 1'b0;
    end else if (adv) begin
      if (s2_valid) begin
        acc     <= acc_next;
        acc_ovf <= ovf_next;
      end
      if (s2_valid && s2_last) begin
        out_valid  <= 1'b1;
        ofm_output <= OUTPUT_WIDTH'(fin_sat);
        out_sat    <= fin_clip || ovf_next;
      end else begin
        out_valid  <= 1'b0;
      end
    end
  end

  // Group bias and ReLU mode, taken from the first beat of each group.
  always_ff @(posedge clk) begin
    if (adv && s2_valid && s2_first) begin
      grp_bias <= s2_bias;
      grp_relu <= s2_relu;
    end
  end

endmodule

// File: tb/tb_pe_arr_acc.sv
// Self-checking bench for pe_arr_acc: beat-level arithmetic model with an
// expected-result queue, one compare process, and literal expectations.
module tb_pe_arr_acc;
  import pe_arr_pkg::*;

  localparam int N  = 9;
  localparam int IW = 8;
  localparam int WW = 8;
  localparam int BW = 8;
  localparam int AW = 32;
  localparam int OW = 20;

  localparam longint ACC_MAX = (longint'(1) <<< (AW - 1)) - 1;
  localparam longint ACC_MIN = -(longint'(1) <<< (AW - 1));
  localparam longint OUT_MAX = (longint'(1) <<< (OW - 1)) - 1;
  localparam longint OUT_MIN = -(longint'(1) <<< (OW - 1));

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_valid, in_ready, in_last, relu_en;
  logic signed [BW-1:0]  bias_input;
  logic signed [IW-1:0]  ifm_input [N];
  logic signed [WW-1:0]  wgt_input [N];
  logic                  out_valid, out_ready, out_sat;
  logic signed [OW-1:0]  ofm_output;

  pe_arr_acc #(
    .IFM_WIDTH    (IW),
    .WGT_WIDTH    (WW),
    .BIAS_WIDTH   (BW),
    .PE_ARR_SIZE  (N),
    .ACC_WIDTH    (AW),
    .OUTPUT_WIDTH (OW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_last    (in_last),
    .relu_en    (relu_en),
    .bias_input (bias_input),
    .ifm_input  (ifm_input),
    .wgt_input  (wgt_input),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ofm_output (ofm_output),
    .out_sat    (out_sat)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    longint val;
    bit     sat;
  } exp_t;

  exp_t   exp_q [$];
  exp_t   e;
  longint m_acc   = 0;
  bit     m_ovf   = 0;
  bit     m_first = 1;
  longint m_bias  = 0;
  bit     m_relu  = 0;

  int     cyc = 0;
  int     acc_last_cyc = 0;
  int     rise_cyc = 0;
  int     rise_cnt = 0;
  int     pop_cnt  = 0;
  bit     prev_valid = 0;
  bit     hold_pend  = 0;
  longint hold_ofm   = 0;
  bit     hold_sat   = 0;
  longint last_ofm   = 0;
  bit     last_sat   = 0;
  int     mark       = 0;

  always @(posedge clk) cyc++;

  task automatic model_beat();
    longint s;
    longint r;
    bit     sat;
    s = 0;
    for (int i = 0; i < N; i++) s += longint'(ifm_input[i]) * longint'(wgt_input[i]);
    if (m_first) begin
      m_acc  = s;
      m_ovf  = 0;
      m_bias = longint'(bias_input);
      m_relu = relu_en;
    end else begin
      m_acc  = m_acc + s;
    end
    if (m_acc > ACC_MAX) begin m_acc = ACC_MAX; m_ovf = 1; end
    if (m_acc < ACC_MIN) begin m_acc = ACC_MIN; m_ovf = 1; end
    if (in_last) begin
      r   = m_acc + m_bias;
      if (m_relu && r < 0) r = 0;
      sat = m_ovf;
      if (r > OUT_MAX) begin r = OUT_MAX; sat = 1; end
      if (r < OUT_MIN) begin r = OUT_MIN; sat = 1; end
      exp_q.push_back('{val: r, sat: sat});
      acc_last_cyc = cyc;
    end
    m_first = in_last;
  endtask

  // Compare process: sampled on the falling edge, mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      m_first = 1;
      m_acc   = 0;
      m_ovf   = 0;
      exp_q.delete();
      hold_pend = 0;
    end else begin
      if (hold_pend) begin
        check("hold_valid", out_valid, 1);
        check("hold_ofm", ofm_output, hold_ofm);
        check("hold_sat", out_sat, hold_sat);
      end
      hold_pend = out_valid && !out_ready;
      hold_ofm  = ofm_output;
      hold_sat  = out_sat;
      check("in_ready_rule", in_ready, !out_valid || out_ready);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("ofm", ofm_output, e.val);
          check("sat", out_sat, e.sat);
        end
        last_ofm = ofm_output;
        last_sat = out_sat;
        pop_cnt++;
      end
      if (in_valid && in_ready) model_beat();
    end
    if (out_valid && !prev_valid) begin
      rise_cyc = cyc;
      rise_cnt++;
    end
    prev_valid = out_valid;
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_lanes(input int a, input int b);
    for (int i = 0; i < N; i++) begin
      ifm_input[i] = IW'(a);
      wgt_input[i] = WW'(b);
    end
  endtask

  // Present one beat (called just after a rising edge); returns once accepted.
  task automatic send(input int b, input bit relu, input bit last);
    int budget;
    budget     = 60;
    bias_input = BW'(b);
    relu_en    = relu;
    in_last    = last;
    in_valid   = 1'b1;
    @(negedge clk);
    while (!in_ready && budget > 0) begin
      budget--;
      @(negedge clk);
    end
    if (!in_ready) check("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Wait until 'need' results have been handed off since 'mark'.
  task automatic wait_pops(input string name, input int need);
    int budget;
    budget = 60;
    while (pop_cnt < mark + need && budget > 0) begin
      budget--;
      @(posedge clk);
    end
    check({name, "_count"}, pop_cnt - mark, need);
    #1;
  endtask

  task automatic wait_result(input string name, input longint ev, input bit es);
    wait_pops(name, 1);
    check(name, last_ofm, ev);
    check({name, "_sat"}, last_sat, es);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_last    = 1'b0;
    relu_en    = 1'b0;
    bias_input = '0;
    out_ready  = 1'b1;
    set_lanes(0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_ofm", ofm_output, 0);
    check("rst_out_sat", out_sat, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_rst", in_ready, 1);

    // Single-beat group: 9 * (1*2) + 3 = 21, three cycles after acceptance.
    set_lanes(1, 2);
    mark = pop_cnt;
    send(3, 0, 1);
    wait_result("t1_single", 21, 0);
    check("t1_latency", rise_cyc - acc_last_cyc, 3);

    // Three beats of 9 * (10*-1) = -90 each.
    set_lanes(10, -1);
    mark = pop_cnt;
    send(0, 0, 0); send(0, 0, 0); send(0, 0, 1);
    wait_result("t2_neg", -270, 0);
    mark = pop_cnt;
    send(0, 1, 0); send(0, 0, 0); send(0, 0, 1);
    wait_result("t2_relu", 0, 0);
    // ReLU raised only on a later beat must be ignored.
    mark = pop_cnt;
    send(0, 0, 0); send(0, 1, 0); send(0, 1, 1);
    wait_result("t2_relu_late", -270, 0);

    // Extreme products: 9 * 16384 = 147456 per beat.
    set_lanes(-128, -128);
    mark = pop_cnt;
    send(0, 0, 0); send(0, 0, 1);
    wait_result("t3_two", 294912, 0);
    mark = pop_cnt;
    send(0, 0, 0); send(0, 0, 0); send(0, 0, 0); send(0, 0, 1);
    wait_result("t3_four_clip", 524287, 1);
    // 9 * (-128*127) = -146304 per beat; four beats clip low.
    set_lanes(-128, 127);
    mark = pop_cnt;
    send(0, 0, 0); send(0, 0, 0); send(0, 0, 0); send(0, 0, 1);
    wait_result("t3_neg_clip", -524288, 1);

    // Backpressure: three results queue up behind a stalled consumer.
    out_ready = 1'b0;
    mark = pop_cnt;
    set_lanes(1, 2);  send(3, 0, 1);    // 21
    set_lanes(2, 3);  send(-5, 0, 1);   // 49
    set_lanes(-1, 4); send(0, 0, 1);    // -36
    set_lanes(3, 3);
    fork
      send(1, 0, 1);                    // 82, must wait for the stall to clear
      begin
        repeat (5) begin
          @(negedge clk);
          check("stall_in_ready", in_ready, 0);
          check("stall_valid", out_valid, 1);
          check("stall_ofm", ofm_output, 21);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_pops("t4_drain", 4);
    check("t4_last", last_ofm, 82);

    // Reset mid-group, also discarding a held result.
    out_ready = 1'b0;
    set_lanes(5, 5);
    send(0, 0, 1);
    send(0, 0, 0); send(0, 0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    check("midrst_out_valid", out_valid, 0);
    rst       = 1'b0;
    out_ready = 1'b1;
    set_lanes(1, 1);
    mark = pop_cnt;
    send(0, 0, 1);
    wait_result("t5_after_rst", 9, 0);

    // Back-to-back single-beat groups: one result per cycle, no bubbles.
    mark = pop_cnt;
    begin
      int rc;
      rc = rise_cnt;
      for (int g = 0; g < 8; g++) begin
        for (int i = 0; i < N; i++) begin
          ifm_input[i] = IW'(g * 37 - i * 19);
          wgt_input[i] = WW'(i * 23 - g * 11 + 5);
        end
        send(g * 9 - 30, g[0], 1);
      end
      wait_pops("t6_b2b", 8);
      check("t6_no_bubble", rise_cnt - rc, 1);
    end

    // Long group saturates the accumulator: 14570 * 147456 > 2^31 - 1.
    set_lanes(-128, -128);
    mark = pop_cnt;
    for (int k = 0; k < 14569; k++) send(0, 0, 0);
    send(0, 0, 1);
    wait_result("t7_acc_sat", 524287, 1);

    repeat (5) @(posedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
